branch_predict_pc: RTL
======================

# branch_predict_pc

Parametrised fetch program counter with an integrated direct-mapped branch target buffer (BTB) and per-entry saturating direction counters. Each cycle it predicts the next fetch address from the current PC. When a branch or jump resolves in the MEM stage, it trains the table and corrects the PC on a misprediction. It sits at the head of the pipeline, feeding the instruction-memory address. It replaces static "fall through then flush" handling with predicted redirects, so a correctly predicted taken branch costs no flush.

## Interface
Parameters:
- PC_INIT, 0, reset value of `pc`.
- ENTRIES, 16, number of BTB entries; power of two, ≥2; IDX = log2(ENTRIES).
- CTR_BITS, 2, width of each direction counter; ≥1.

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous, active-low reset.
- stall  input  1  hold `pc` (fetch/decode stall).
- pc  output  32  current fetch address (registered).
- pred_taken  output  1  prediction for `pc` (combinational).
- pred_target  output  32  predicted target for `pc`; 0 when `pred_taken`=0.
- resolve_valid  input  1  a control-flow instruction resolved in MEM this cycle.
- resolve_pc  input  32  PC of the resolving instruction.
- resolve_taken  input  1  actual outcome (jumps always 1).
- resolve_target  input  32  actual taken target.
- resolve_pred_taken  input  1  `pred_taken` carried down the pipeline with this instruction.
- resolve_pred_target  input  32  `pred_target` carried down the pipeline with this instruction.
- mispredict  output  1  flush request for IF/ID, ID/EX and EX/MEM (combinational).
- mispredict_count  output  32  saturating count of mispredictions.

## Operation
- Index = pc[IDX+1:2]; tag = pc[31:IDX+2]. pc[1:0] is ignored for lookup.
- Each entry holds valid, tag, target[31:0] and ctr[CTR_BITS-1:0].
- Hit: valid and tag match. `pred_taken` = hit && ctr[MSB].
- mispredict = resolve_valid && (resolve_taken != resolve_pred_taken || (resolve_taken && resolve_target != resolve_pred_target)).
- Next-PC priority, highest first:
  1. mispredict: resolve_taken ? resolve_target : resolve_pc+4. This overrides stall.
  2. stall: hold pc.
  3. pred_taken: pred_target.
  4. otherwise: pc+4.
- All PC arithmetic is 32-bit modulo 2^32; 0xFFFFFFFC+4 wraps to 0.
- Training, on resolve_valid, indexed by resolve_pc:
  - Hit, taken: ctr saturating +1; target ← resolve_target.
  - Hit, not taken: ctr saturating −1; target unchanged.
  - Miss, taken: allocate/overwrite the entry. valid=1, tag from resolve_pc, target=resolve_target, ctr=2^(CTR_BITS−1) (weakly taken).
  - Miss, not taken: no change.
- Training is independent of stall.
- mispredict_count increments by 1 on each cycle mispredict=1 and saturates at 0xFFFFFFFF.

## Timing
- pc, table and mispredict_count are updated on the rising CLK edge.
- pred_taken, pred_target and mispredict are combinational, with zero-cycle latency from pc and resolve_* inputs.
- Correct taken prediction: the target is fetched the cycle after the branch. Misprediction: the corrected PC appears the cycle after resolve_valid.
- Same-cycle lookup and train on the same index: the lookup sees pre-update contents (no bypass). The update is visible the next cycle.
- Reset (any time, including mid-redirect), effective immediately:
  - pc=PC_INIT, mispredict_count=0.
  - All valid=0; all ctr=2^(CTR_BITS−1)−1 (weakly not taken).
  - Hence pred_taken=0 and pred_target=0.
  - mispredict follows its inputs.
- A table update during reset is discarded.
- With CTR_BITS=1, increment sets ctr=1 and decrement clears it.

## Test plan
- Reset with PC_INIT=0x200, no stall, no resolve: pc=0x200, then 0x204, 0x208; pred_taken=0 throughout.
- Cold branch at 0x208 resolves taken to 0x100 with resolve_pred_taken=0: mispredict=1 that cycle, next pc=0x100. Entry 2 becomes valid with ctr=2. On the next visit to 0x208, pred_taken=1, pred_target=0x100.
- Trained entry, branch resolves not taken twice: ctr goes 3→2→1 (after a prior taken) and pred_taken drops to 0. Mispredict on a not-taken outcome redirects to resolve_pc+4.
- Aliasing with ENTRIES=16: train 0x40 taken, then look up 0x80 (same index, different tag): pred_taken=0. Taken resolve at 0x80 overwrites the entry, and a later lookup of 0x40 misses.
- stall=1 together with a mispredict redirect: pc takes the redirect. stall=1 alone: pc holds. Same-cycle lookup and train of one index returns old data.
- Saturation and reset: force 3 mispredicts, mispredict_count=3. Assert nRST mid-run: all outputs return to reset values asynchronously, and the first post-reset lookup of a previously trained PC misses.

Source files
------------

// File: rtl/branch_predict_pc.sv
// Fetch program counter with a direct-mapped branch target buffer.
// Each BTB entry holds a tag, a taken target and a saturating direction
// counter. Lookups use the current PC. Training and misprediction
// correction come from the branch resolving in MEM.
`timescale 1ns/1ps
module branch_predict_pc #(
    parameter logic [31:0] PC_INIT  = 32'h0,
    parameter int          ENTRIES  = 16,
    parameter int          CTR_BITS = 2
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        stall,
    output logic [31:0] pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        resolve_valid,
    input  logic [31:0] resolve_pc,
    input  logic        resolve_taken,
    input  logic [31:0] resolve_target,
    input  logic        resolve_pred_taken,
    input  logic [31:0] resolve_pred_target,
    output logic        mispredict,
    output logic [31:0] mispredict_count
);

    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = 30 - IDX;

    // Counter encodings: MSB set means "predict taken".
    localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);

    logic [31:0]         pc_q, pc_d;
    logic [31:0]         count_q, count_d;
    logic                valid_q  [ENTRIES];
    logic [TAGW-1:0]     tag_q    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

    logic [IDX-1:0]  lkIdx, resIdx;
    logic [TAGW-1:0] lkTag, resTag;
    logic            lkHit, resHit;

    assign lkIdx  = pc_q[IDX+1:2];
    assign lkTag  = pc_q[31:IDX+2];
    assign resIdx = resolve_pc[IDX+1:2];
    assign resTag = resolve_pc[31:IDX+2];

    assign lkHit  = valid_q[lkIdx] && (tag_q[lkIdx] == lkTag);
    assign resHit = valid_q[resIdx] && (tag_q[resIdx] == resTag);

    assign pc               = pc_q;
    assign mispredict_count = count_q;
    assign pred_taken       = lkHit && ctr_q[lkIdx][CTR_BITS-1];
    assign pred_target      = pred_taken ? target_q[lkIdx] : 32'h0;

    assign mispredict = resolve_valid &&
                        ((resolve_taken != resolve_pred_taken) ||
                         (resolve_taken && (resolve_target != resolve_pred_target)));

    // Next fetch address: a redirect from MEM beats a stall, which beats the prediction.
    always_comb begin
        pc_d = pc_q + 32'd4;
        if (mispredict) begin
            pc_d = resolve_taken ? resolve_target : (resolve_pc + 32'd4);
        end else if (stall) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = pred_target;
        end
    end

    // Saturating misprediction counter.
    always_comb begin
        count_d = count_q;
        if (mispredict && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end
    end

    // PC and misprediction count registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_q    <= PC_INIT;
            count_q <= 32'h0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    // BTB training from the resolving branch; runs regardless of stall.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'h0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else if (resolve_valid) begin
            if (resHit) begin
                if (resolve_taken) begin
                    if (ctr_q[resIdx] != CTR_MAX) begin
                        ctr_q[resIdx] <= ctr_q[resIdx] + CTR_BITS'(1);
                    end
                    target_q[resIdx] <= resolve_target;
                end else if (ctr_q[resIdx] != '0) begin
                    ctr_q[resIdx] <= ctr_q[resIdx] - CTR_BITS'(1);
                end
            end else if (resolve_taken) begin
                valid_q[resIdx]  <= 1'b1;
                tag_q[resIdx]    <= resTag;
                target_q[resIdx] <= resolve_target;
                ctr_q[resIdx]    <= CTR_WT;
            end
        end
    end

endmodule
